// File: rtl/settings_pkg.sv
// Shared widths for the moving-average datapath, plus the window decode helpers
// used by the output buffer.
package settings_pkg;

  localparam int DATA_SIZE          = 16;
  localparam int FULL_SIZE          = 24;
  localparam int WINDOW_SIZE        = 6;
  localparam int FIFO_DEPTH_DEFAULT = 16;
  localparam int SHIFT_W            = $clog2(WINDOW_SIZE + 1);

  function automatic logic window_is_onehot(input logic [WINDOW_SIZE:0] window);
    return $onehot(window);
  endfunction

  // A malformed window (zero or several bits set) decodes to a shift of 0.
  function automatic logic [SHIFT_W-1:0] window_to_shift(input logic [WINDOW_SIZE:0] window);
    logic [SHIFT_W-1:0] s;
    s = '0;
    if ($onehot(window)) begin
      for (int i = 0; i <= WINDOW_SIZE; i++) begin
        if (window[i]) s = SHIFT_W'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/moving_average_result_fifo.sv
// First-word-fall-through result FIFO: storage, wrap pointers with an extra MSB,
// and an occupancy count. A write to a full FIFO is accepted only if a read pops the same cycle.
module moving_average_result_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      wr_en_i,
  input  logic [W-1:0]              wr_data_i,
  input  logic                      rd_en_i,
  output logic [W-1:0]              rd_data_o,
  output logic                      rd_valid_o,
  output logic [$clog2(DEPTH):0]    fill_level_o,
  output logic                      drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_q, count_d;
  logic         empty, full, do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Reads are ignored while empty, so the pointers never pass each other.
  assign do_rd  = rd_en_i && !empty;
  assign do_wr  = wr_en_i && (!full || do_rd);
  assign drop_o = wr_en_i && full && !do_rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_valid_o   = !empty;
  assign rd_data_o    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fill_level_o = count_q;

endmodule

// File: rtl/moving_average_output_buffer.sv
// Normalizes accumulated window sums (shift by log2 window, saturate) and buffers them
// in a FWFT FIFO. Define MOVING_AVERAGE_ROUNDING_EN for round-half-up instead of floor.
module moving_average_output_buffer
  import settings_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [FULL_SIZE-1:0]   output_data,
  input  logic                          output_data_valid,
  input  logic [WINDOW_SIZE:0]          window,
  output logic signed [DATA_SIZE-1:0]   norm_data,
  output logic                          norm_valid,
  input  logic                          norm_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic                          window_error
);

  localparam logic signed [FULL_SIZE:0] SAT_MAX = (FULL_SIZE+1)'((2 ** (DATA_SIZE - 1)) - 1);
  localparam logic signed [FULL_SIZE:0] SAT_MIN = ~SAT_MAX;

  logic [SHIFT_W-1:0]           shift;
  logic signed [FULL_SIZE:0]    widened, addend, quot_d;
  // One guard bit above FULL_SIZE absorbs the rounding carry on the largest sums.
  logic signed [FULL_SIZE:0]    s1_quot_q;
  logic                         s1_valid_q;
  logic signed [DATA_SIZE-1:0]  sat_data;
  logic                         fifo_drop;
  logic                         overflow_q, overflow_d;
  logic                         window_error_q, window_error_d;

  always_comb begin
    shift   = window_to_shift(window);
    widened = {output_data[FULL_SIZE-1], output_data};
`ifdef MOVING_AVERAGE_ROUNDING_EN
    addend  = (shift != '0) ? ((FULL_SIZE+1)'(1) << (shift - SHIFT_W'(1))) : '0;
`else
    addend  = '0;
`endif
    quot_d  = (widened + addend) >>> shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_quot_q  <= '0;
    end else begin
      s1_valid_q <= output_data_valid;
      if (output_data_valid) s1_quot_q <= quot_d;
    end
  end

  always_comb begin
    if (s1_quot_q > SAT_MAX)      sat_data = SAT_MAX[DATA_SIZE-1:0];
    else if (s1_quot_q < SAT_MIN) sat_data = SAT_MIN[DATA_SIZE-1:0];
    else                          sat_data = s1_quot_q[DATA_SIZE-1:0];
  end

  moving_average_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_SIZE)
  ) u_fifo (
    .clk_i        (clk),
    .reset_i      (reset),
    .wr_en_i      (s1_valid_q),
    .wr_data_i    (sat_data),
    .rd_en_i      (norm_ready),
    .rd_data_o    (norm_data),
    .rd_valid_o   (norm_valid),
    .fill_level_o (fill_level),
    .drop_o       (fifo_drop)
  );

  always_comb begin
    overflow_d     = overflow_q | fifo_drop;
    window_error_d = window_error_q | (output_data_valid & ~window_is_onehot(window));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q     <= 1'b0;
      window_error_q <= 1'b0;
    end else begin
      overflow_q     <= overflow_d;
      window_error_q <= window_error_d;
    end
  end

  assign overflow     = overflow_q;
  assign window_error = window_error_q;

endmodule
